// File: rtl/mant_mul_seq.sv
// Sequential 24x24 shift-add mantissa multiplier, one multiplier bit per clock.
// Optional early termination on an all-zero multiplier tail: define MANT_MUL_EARLY_TERM_EN.
module mant_mul_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [23:0] i_mant_a,
  input  logic [23:0] i_mant_b,
  input  logic        i_ready,
  output logic        o_ready,
  output logic        o_valid,
  output logic [47:0] o_product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [23:0] a_r;
  logic [48:0] p_r;
  logic [4:0]  cnt_r;
  logic        ready_r;
  logic        valid_r;
  logic [47:0] product_r;

  logic [24:0] sum_s;
  logic [48:0] p_next_s;

  // One shift-add iteration: conditional add of A into the upper half, then shift right.
  always_comb begin
    sum_s = 25'd0;
    if (p_r[0]) begin
      sum_s = p_r[48:24] + {1'b0, a_r};
    end else begin
      sum_s = p_r[48:24];
    end
    p_next_s = {1'b0, sum_s, p_r[23:1]};
  end

`ifdef MANT_MUL_EARLY_TERM_EN
  logic [23:0] tail_mask_s;
  logic [5:0]  remaining_s;
  logic        early_exit_s;
  logic [47:0] early_product_s;

  // Remaining multiplier bits are P[23-cnt:0]; once all zero only plain shifts are left.
  always_comb begin
    tail_mask_s     = 24'hFF_FFFF >> cnt_r;
    remaining_s     = 6'd24 - {1'b0, cnt_r};
    early_exit_s    = ((p_r[23:0] & tail_mask_s) == 24'd0);
    early_product_s = p_r[47:0] >> remaining_s;
  end
`endif

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      a_r       <= 24'd0;
      p_r       <= 49'd0;
      cnt_r     <= 5'd0;
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      product_r <= 48'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            a_r     <= i_mant_a;
            p_r     <= {25'd0, i_mant_b};
            cnt_r   <= 5'd0;
            ready_r <= 1'b0;
            state_r <= BUSY;
          end
        end
        BUSY: begin
`ifdef MANT_MUL_EARLY_TERM_EN
          if (early_exit_s) begin
            product_r <= early_product_s;
            valid_r   <= 1'b1;
            state_r   <= DONE;
          end else begin
            p_r   <= p_next_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == 5'd23) begin
              product_r <= p_next_s[47:0];
              valid_r   <= 1'b1;
              state_r   <= DONE;
            end
          end
`else
          p_r   <= p_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd23) begin
            product_r <= p_next_s[47:0];
            valid_r   <= 1'b1;
            state_r   <= DONE;
          end
`endif
        end
        DONE: begin
          if (i_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready   = ready_r;
  assign o_valid   = valid_r;
  assign o_product = product_r;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq: directed corners, backpressure, mid-run reset,
// and a randomised scoreboard sweep with consumer stalls.
module tb_mant_mul_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [23:0] i_mant_a;
  logic [23:0] i_mant_b;
  logic        i_ready;
  logic        o_ready;
  logic        o_valid;
  logic [47:0] o_product;

  logic [47:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef MANT_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mant_mul_seq dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_mant_a (i_mant_a),
    .i_mant_b (i_mant_b),
    .i_ready  (i_ready),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_product(o_product)
  );

  always #5 i_clk = ~i_clk;

  // Edges from accept to o_valid: full 24, or first k where the multiplier tail b>>k is zero.
  function automatic int exp_lat(input logic [23:0] b);
    int lat = 24;
    if (EARLY) begin
      for (int k = 23; k >= 0; k--) begin
        if ((b >> k) == 24'd0) lat = k + 1;
      end
    end
    return lat;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic accept(input logic [23:0] a, input logic [23:0] b);
    i_mant_a = a;
    i_mant_b = b;
    i_valid  = 1'b1;
    step();
    i_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (o_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
    i_mant_a = 24'h123456; i_mant_b = 24'h654321;
    step(); step();
    i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++; if (o_product !== 48'd0) begin n_fail++; $display("FAIL reset_product: got %h want 0", o_product); end
  endtask

  task automatic test_corner_products();
    logic [23:0] ta[4];
    logic [23:0] tb[4];
    logic [47:0] te[4];
    logic [47:0] e;
    int lat;
    ta[0] = 24'hFFFFFF; tb[0] = 24'hFFFFFF; te[0] = 48'hFFFF_FE00_0001;
    ta[1] = 24'h800000; tb[1] = 24'h800000; te[1] = 48'h4000_0000_0000;
    ta[2] = 24'h123456; tb[2] = 24'h000000; te[2] = 48'h0000_0000_0000;
    ta[3] = 24'h000001; tb[3] = 24'h000010; te[3] = 48'h0000_0000_0010;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL corner%0d_ready: got %b want 1", i, o_ready); end
      exp_q.push_back(te[i]);
      accept(ta[i], tb[i]);
      wait_valid(lat);
      n_checks++; if (lat != exp_lat(tb[i])) begin n_fail++; $display("FAIL corner%0d_latency: got %0d want %0d", i, lat, exp_lat(tb[i])); end
      e = exp_q.pop_front();
      n_checks++; if (o_product !== e) begin n_fail++; $display("FAIL corner%0d_product: got %h want %h", i, o_product, e); end
      step();
      n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL corner%0d_release: valid %b ready %b want 0 1", i, o_valid, o_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] e;
    int lat;
    i_ready = 1'b0;
    exp_q.push_back(48'h0000_0000_000F);
    accept(24'd3, 24'd5);
    wait_valid(lat);
    n_checks++; if (lat != exp_lat(24'd5)) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, exp_lat(24'd5)); end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_product !== e) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid %b ready %b product %h want 1 0 %h", i, o_valid, o_ready, o_product, e);
      end
      i_mant_a = 24'hABCDEF; i_mant_b = 24'h111111; i_valid = 1'b1;
      step();
      i_valid = 1'b0;
    end
    i_ready = 1'b1;
    step();
    n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid %b ready %b want 0 1", o_valid, o_ready); end
  endtask

  task automatic test_reset_mid_busy();
    logic [47:0] e;
    int lat;
    bit seen;
    accept(24'hFFFFFF, 24'hFFFFFF);
    for (int i = 0; i < 10; i++) step();
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    i_mant_a = 24'h00FFFF; i_mant_b = 24'h00FFFF;
    step();
    i_rst = 1'b0; i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
    n_checks++; if (o_product !== 48'd0) begin n_fail++; $display("FAIL midrst_product: got %h want 0", o_product); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", o_ready); end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_valid === 1'b1 || o_ready !== 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_discard: got activity 1 want 0"); end
    exp_q.push_back(48'h0000_0000_003F);
    accept(24'd7, 24'd9);
    wait_valid(lat);
    n_checks++; if (lat != exp_lat(24'd9)) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", lat, exp_lat(24'd9)); end
    e = exp_q.pop_front();
    n_checks++; if (o_product !== e) begin n_fail++; $display("FAIL midrst_product2: got %h want %h", o_product, e); end
    step();
  endtask

  function automatic logic [23:0] pick_operand();
    logic [23:0] v;
    case ($urandom_range(0, 7))
      0: v = 24'd0;
      1: v = 24'hFFFFFF;
      2: v = 24'd1 << $urandom_range(0, 23);
      3: v = 24'($urandom_range(0, 255));
      default: v = 24'($urandom());
    endcase
    return v;
  endfunction

  task automatic test_random_sweep();
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] e;
    int lat;
    int guard;
    int consumed = 0;
    int issued = 0;
    bit done;
    for (int i = 0; i < 1200; i++) begin
      a = pick_operand();
      b = pick_operand();
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL sweep%0d_ready: got %b want 1", i, o_ready); end
      exp_q.push_back({24'd0, a} * {24'd0, b});
      issued++;
      i_ready = 1'($urandom_range(0, 1));
      accept(a, b);
      lat = 0; guard = 0; done = 1'b0;
      while (!done && guard < 200) begin
        if (o_valid === 1'b1 && lat == 0) begin
          lat = guard;
          n_checks++; if (lat != exp_lat(b)) begin n_fail++; $display("FAIL sweep%0d_latency: got %0d want %0d", i, lat, exp_lat(b)); end
        end
        i_ready = 1'($urandom_range(0, 1));
        if (o_valid === 1'b1 && i_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hX;
          consumed++;
          n_checks++; if (o_product !== e) begin n_fail++; $display("FAIL sweep%0d_product: a %h b %h got %h want %h", i, a, b, o_product, e); end
          step();
          n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL sweep%0d_once: valid got %b want 0", i, o_valid); end
          done = 1'b1;
        end else begin
          step();
          guard++;
        end
      end
      if (!done) begin
        n_checks++; n_fail++;
        $display("FAIL sweep%0d_timeout: got no result want result", i);
        i_rst = 1'b1; step(); i_rst = 1'b0;
        exp_q.delete();
      end
    end
    i_ready = 1'b1;
    n_checks++; if (consumed != issued || exp_q.size() != 0) begin n_fail++; $display("FAIL sweep_count: consumed %0d left %0d want %0d 0", consumed, exp_q.size(), issued); end
  endtask

  initial begin
    test_reset();
    test_corner_products();
    test_backpressure();
    test_reset_mid_busy();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
